sort_drain: RTL
===============

SORT_DRAIN -- requirements
Module: sort_drain

Interface
- REQ-001 Parameter P_LOG, default 9: log2 of the number of records per block (N = 1<<P_LOG).
- REQ-002 Parameter DATW, default 64: record width in bits.
- REQ-003 Parameter KEYW, default 32: key width; the key is record bits [KEYW-1:0].
- REQ-004 CLK  input  1  clock; all state updates on the rising edge.
- REQ-005 RST  input  1  reset, synchronous, active-high.
- REQ-006 DIN  input  DATW<<P_LOG  sorted block from the sorter; record i = DIN[DATW*(i+1)-1 : DATW*i].
- REQ-007 DINEN  input  1  one-cycle strobe; DIN is valid this cycle and cannot be stalled.
- REQ-008 DOT  output  DATW  current output record.
- REQ-009 DOTEN  output  1  DOT valid.
- REQ-010 DORDY  input  1  downstream ready; a transfer occurs on a cycle with DOTEN && DORDY.
- REQ-011 DLAST  output  1  high with DOTEN when DOT is record N-1 of its block.
- REQ-012 BUSY  output  1  at least one block is buffered.
- REQ-013 OVF  output  1  sticky flag: a block was dropped.
- REQ-014 SORTERR  output  1  sticky flag: an out-of-order key was emitted.

Function
- REQ-015 The block shall have two block slots (ping-pong), a write pointer, a read pointer, an occupancy count (0..2) and an element index e (0..N-1).
- REQ-016 DINEN with count<2 shall store DIN into the write slot, toggle the write pointer and increment count at that edge.
- REQ-017 DOTEN shall be driven from registered state only: DOTEN = (count!=0), so the first record is valid in the cycle after DINEN is sampled.
- REQ-018 DOT shall equal record e of the read slot; records shall be emitted in ascending index order (record 0 first).
- REQ-019 DOT, DLAST and e shall hold stable while DOTEN && !DORDY.
- REQ-020 On a transfer with e<N-1, e shall increment.
- REQ-021 On a transfer with e=N-1, e shall wrap to 0, the read pointer shall toggle and count shall decrement.
- REQ-022 Simultaneous DINEN and final-element transfer with count=2: the incoming block shall be accepted, count stays 2, and OVF shall not be set.
- REQ-023 Simultaneous DINEN and final-element transfer with count=1: the block shall be accepted and count stays 1.
- REQ-024 DINEN with count=2 and no final-element transfer that cycle: DIN shall be discarded, buffered blocks untouched, and OVF set.
- REQ-025 OVF and SORTERR shall remain 1 until RST.
- REQ-026 SORTERR shall be set on a transfer with e!=0 whose key is less (unsigned) than the key of the previous transfer in the same block.
- REQ-027 Keys shall be compared across records only within one block; e=0 never flags.
- REQ-028 BUSY = (count!=0).
- REQ-029 N=1 (P_LOG=0) shall be supported: every emitted record has DLAST=1 and SORTERR never sets.

Reset
- REQ-030 While RST=1 at an edge: count=0, both pointers=0, e=0, OVF=0, SORTERR=0, DINEN ignored.
- REQ-031 All outputs after reset: DOTEN=0, DLAST=0, BUSY=0, OVF=0, SORTERR=0; DOT don't-care while DOTEN=0.
- REQ-032 RST mid-block shall discard all buffered data; no record of a pre-reset block is emitted after RST deasserts.
- REQ-033 Slot data registers need no reset.

Verification (bench P_LOG=2, DATW=64, KEYW=32, upper record bits all ones)
- REQ-034 One block with keys 1,2,3,4 and DORDY=1 -> DOT keys 1,2,3,4 on four consecutive cycles starting the cycle after DINEN; DLAST on key 4; BUSY falls after; SORTERR=0.
- REQ-035 Keys 1,2,3,4 with DORDY pattern 1,0,1,0,1,0,1 -> each key held through its DORDY=0 cycle; output order 1,2,3,4; no duplicates.
- REQ-036 With DORDY=0: blocks A(1..4), B(5..8), then C(9..12) -> OVF=1; releasing DORDY emits 1..8 only.
- REQ-037 A and B buffered, C strobed in the cycle key 4 of A transfers -> OVF=0; output 1..12 in order.
- REQ-038 Block keys 4,3,2,1 -> SORTERR rises after the second transfer and stays 1 through a following in-order block until RST.
- REQ-039 RST for one cycle after two transfers of a block -> DOTEN=0 and BUSY=0 the next cycle; nothing emitted after release until a new DINEN.

Source files
------------

// File: rtl/sort_drain.sv
// sort_drain: ping-pong buffer that captures whole sorted blocks from a sorter
// and drains them one record per transfer toward a ready/valid consumer.
//
// Ports
//   CLK      clock, all state updates on the rising edge
//   RST      synchronous active-high reset
//   DIN      one block of N = 1<<P_LOG records, record i at DIN[DATW*i +: DATW]
//   DINEN    one-cycle strobe, DIN valid (cannot be stalled)
//   DOT      current output record (record e of the read slot)
//   DOTEN    DOT valid (at least one block buffered)
//   DORDY    downstream ready; a transfer happens on DOTEN && DORDY
//   DLAST    DOT is the last record of its block
//   BUSY     at least one block buffered
//   OVF      sticky: an incoming block was dropped because both slots were full
//   SORTERR  sticky: a key smaller than its predecessor in the same block was emitted
module sort_drain #(
    parameter int P_LOG = 9,
    parameter int DATW  = 64,
    parameter int KEYW  = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [(DATW<<P_LOG)-1:0] DIN,
    input  logic                    DINEN,
    output logic [DATW-1:0]         DOT,
    output logic                    DOTEN,
    input  logic                    DORDY,
    output logic                    DLAST,
    output logic                    BUSY,
    output logic                    OVF,
    output logic                    SORTERR
);

    localparam int N  = 1 << P_LOG;
    localparam int BW = DATW * N;
    // Element index needs at least one bit even when a block holds one record.
    localparam int EW = (P_LOG > 0) ? P_LOG : 1;
    localparam logic [EW-1:0] E_LAST = EW'(N - 1);

    logic [BW-1:0]   slot_a;
    logic [BW-1:0]   slot_b;
    logic [BW-1:0]   rd_block;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic [EW-1:0]   e;
    logic [KEYW-1:0] prev_key;
    logic [KEYW-1:0] cur_key;
    logic            ovf_q;
    logic            sorterr_q;

    logic            xfer;
    logic            fin;
    logic            accept;

    assign rd_block = rd_ptr ? slot_b : slot_a;
    assign DOT      = rd_block[DATW*int'(e) +: DATW];
    assign cur_key  = DOT[KEYW-1:0];

    assign DOTEN    = (count != 2'd0);
    assign BUSY     = (count != 2'd0);
    assign DLAST    = DOTEN && (e == E_LAST);
    assign OVF      = ovf_q;
    assign SORTERR  = sorterr_q;

    assign xfer     = DOTEN && DORDY;
    assign fin      = xfer && (e == E_LAST);
    // When full, the final-element transfer frees the read slot this same
    // edge; with both slots occupied the write pointer equals the read
    // pointer, so the incoming block lands exactly in the slot being vacated.
    assign accept   = DINEN && ((count != 2'd2) || fin);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            e         <= '0;
            prev_key  <= '0;
            ovf_q     <= 1'b0;
            sorterr_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fin) begin
                rd_ptr <= ~rd_ptr;
                e      <= '0;
            end else if (xfer) begin
                e <= e + EW'(1);
            end
            count <= count + {1'b0, accept} - {1'b0, fin};
            if (xfer) begin
                prev_key <= cur_key;
                // Element 0 starts a new block, so it is never compared.
                if ((e != '0) && (cur_key < prev_key)) begin
                    sorterr_q <= 1'b1;
                end
            end
            if (DINEN && !accept) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Slot storage carries no reset; stale contents are never visible
    // because DOTEN depends only on count.
    always_ff @(posedge CLK) begin
        if (!RST && accept) begin
            if (wr_ptr) begin
                slot_b <= DIN;
            end else begin
                slot_a <= DIN;
            end
        end
    end

endmodule
